// File: rtl/qr_bounds.sv
// Bounding box of QR finder-pattern flags: first/last flagged index per axis, one index per clock.
// Optional QR_BOUNDS_RUN_FILTER_EN: only runs of >= MIN_RUN consecutive flags are counted.
module qr_bounds #(
    parameter int unsigned N       = 480,
    parameter int unsigned IW      = 9,
    parameter int unsigned MIN_RUN = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [N-1:0]        horz_patterns,
    input  logic [N-1:0]        vert_patterns,
    input  logic                start_bound,
    output logic [1:0][IW-1:0]  bound_x,
    output logic [1:0][IW-1:0]  bound_y,
    output logic                valid_bound
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    state_e             state_q;
    logic [IW-1:0]      idx_q;
    // Axis 0 = x (horizontal), axis 1 = y (vertical); vectors shift right so bit 0 is idx_q.
    logic [1:0][N-1:0]  pat_q;
    logic [1:0][IW-1:0] lo_q;
    logic [1:0][IW-1:0] hi_q;
    logic [1:0]         found_q;

    logic [1:0]         take_lo;
    logic [1:0]         take_hi;
    logic [1:0][IW-1:0] lo_val;

`ifdef QR_BOUNDS_RUN_FILTER_EN
    localparam int unsigned RW      = $clog2(MIN_RUN + 1);
    localparam logic [RW-1:0] RunMax  = RW'(MIN_RUN);
    localparam logic [RW-1:0] RunLast = RW'(MIN_RUN - 1);

    logic [1:0][RW-1:0] run_cnt_q;
    logic [1:0][IW-1:0] run_start_q;

    // A run qualifies on the bit that brings it to MIN_RUN; lo then points back to its start.
    always_comb begin
        take_lo = '0;
        take_hi = '0;
        lo_val  = '0;
        for (int a = 0; a < 2; a++) begin
            take_hi[a] = pat_q[a][0] && (run_cnt_q[a] >= RunLast);
            take_lo[a] = pat_q[a][0] && (run_cnt_q[a] == RunLast) && !found_q[a];
            lo_val[a]  = (run_cnt_q[a] == '0) ? idx_q : run_start_q[a];
        end
    end
`else
    always_comb begin
        take_lo = '0;
        take_hi = '0;
        lo_val  = '0;
        for (int a = 0; a < 2; a++) begin
            take_hi[a] = pat_q[a][0];
            take_lo[a] = pat_q[a][0] && !found_q[a];
            lo_val[a]  = idx_q;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pat_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            found_q     <= '0;
            bound_x     <= '0;
            bound_y     <= '0;
            valid_bound <= 1'b0;
`ifdef QR_BOUNDS_RUN_FILTER_EN
            run_cnt_q   <= '0;
            run_start_q <= '0;
`endif
        end else begin
            valid_bound <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_bound) begin
                        pat_q[0] <= horz_patterns;
                        pat_q[1] <= vert_patterns;
                        idx_q    <= '0;
                        found_q  <= '0;
                        // Cleared so an axis with no flags reports lo=hi=0.
                        lo_q     <= '0;
                        hi_q     <= '0;
`ifdef QR_BOUNDS_RUN_FILTER_EN
                        run_cnt_q   <= '0;
                        run_start_q <= '0;
`endif
                        state_q  <= StScan;
                    end
                end
                StScan: begin
                    for (int a = 0; a < 2; a++) begin
                        if (take_lo[a]) begin
                            lo_q[a]    <= lo_val[a];
                            found_q[a] <= 1'b1;
                        end
                        if (take_hi[a]) begin
                            hi_q[a] <= idx_q;
                        end
                        pat_q[a] <= pat_q[a] >> 1;
`ifdef QR_BOUNDS_RUN_FILTER_EN
                        if (pat_q[a][0]) begin
                            if (run_cnt_q[a] == '0) begin
                                run_start_q[a] <= idx_q;
                            end
                            if (run_cnt_q[a] != RunMax) begin
                                run_cnt_q[a] <= run_cnt_q[a] + 1'b1;
                            end
                        end else begin
                            run_cnt_q[a] <= '0;
                        end
`endif
                    end
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    bound_x     <= {hi_q[0], lo_q[0]};
                    bound_y     <= {hi_q[1], lo_q[1]};
                    valid_bound <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_qr_bounds.sv
// Randomized self-checking bench for qr_bounds against a run-scanning reference model.
module tb_qr_bounds;

    localparam int unsigned N       = 480;
    localparam int unsigned IW      = 9;
    localparam int unsigned MIN_RUN = 4;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b0;
    logic [N-1:0]        horz_patterns = '0;
    logic [N-1:0]        vert_patterns = '0;
    logic                start_bound = 1'b0;
    logic [1:0][IW-1:0]  bound_x;
    logic [1:0][IW-1:0]  bound_y;
    logic                valid_bound;

    int n_checks = 0;
    int n_fail   = 0;

    qr_bounds #(.N(N), .IW(IW), .MIN_RUN(MIN_RUN)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .horz_patterns (horz_patterns),
        .vert_patterns (vert_patterns),
        .start_bound   (start_bound),
        .bound_x       (bound_x),
        .bound_y       (bound_y),
        .valid_bound   (valid_bound)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} from a plain scan over the runs of set bits.
    function automatic logic [2*IW-1:0] model(input logic [N-1:0] v);
        int lo = 0;
        int hi = 0;
        bit found = 1'b0;
        int i = 0;
        int j;
        while (i < N) begin
            if (v[i]) begin
                j = i;
                while (j < N && v[j]) j++;
`ifdef QR_BOUNDS_RUN_FILTER_EN
                if (j - i >= MIN_RUN) begin
`else
                if (j - i >= 1) begin
`endif
                    if (!found) lo = i;
                    found = 1'b1;
                    hi = j - 1;
                end
                i = j;
            end else begin
                i++;
            end
        end
        return {hi[IW-1:0], lo[IW-1:0]};
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] v = '0;
        int mode = $urandom_range(0, 3);
        if (mode == 0) begin
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 7) == 0);
        end else begin
            int nruns = $urandom_range(0, 4);
            for (int r = 0; r < nruns; r++) begin
                int s   = $urandom_range(0, N - 1);
                int len = $urandom_range(1, 40);
                for (int k = 0; k < len; k++) if (s + k < N) v[s + k] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic [N-1:0] range_vec(input int lo, input int hi);
        logic [N-1:0] v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Clocks until valid_bound is seen, sampled 1 time unit after each rising edge.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk_in);
            #1;
            cyc++;
        end while (!valid_bound && cyc < 700);
    endtask

    task automatic count_valids(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_in);
            #1;
            if (valid_bound) cnt++;
        end
    endtask

    task automatic check_bounds(input string tag, input logic [N-1:0] hv, input logic [N-1:0] vv);
        logic [2*IW-1:0] ex = model(hv);
        logic [2*IW-1:0] ey = model(vv);
        check({tag, " x_lo"}, bound_x[0], ex[IW-1:0]);
        check({tag, " x_hi"}, bound_x[1], ex[2*IW-1:IW]);
        check({tag, " y_lo"}, bound_y[0], ey[IW-1:0]);
        check({tag, " y_hi"}, bound_y[1], ey[2*IW-1:IW]);
    endtask

    task automatic run_scan(input string tag, input logic [N-1:0] hv, input logic [N-1:0] vv);
        int cyc;
        @(negedge clk_in);
        horz_patterns = hv;
        vert_patterns = vv;
        start_bound   = 1'b1;
        @(posedge clk_in);
        #1;
        start_bound = 1'b0;
        wait_valid(cyc);
        check({tag, " latency"}, cyc, N + 1);
        check_bounds(tag, hv, vv);
        @(posedge clk_in);
        #1;
        check({tag, " pulse_width"}, valid_bound, 0);
    endtask

    initial begin
        logic [N-1:0] hv;
        logic [N-1:0] vv;
        int cyc;
        int cnt;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("reset valid", valid_bound, 0);
        check("reset bound_x", bound_x, 0);
        check("reset bound_y", bound_y, 0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Three bands, start held high: latency then retrigger period
        hv = range_vec(51, 89) | range_vec(231, 269) | range_vec(401, 439);
        @(negedge clk_in);
        horz_patterns = hv;
        vert_patterns = hv;
        start_bound   = 1'b1;
        @(posedge clk_in);
        #1;
        wait_valid(cyc);
        check("bands latency", cyc, N + 1);
        check_bounds("bands", hv, hv);
        wait_valid(cyc);
        start_bound = 1'b0;
        check("bands period", cyc, N + 2);
        check_bounds("bands repeat", hv, hv);
        @(posedge clk_in);
        #1;
        check("bands pulse_width", valid_bound, 0);

        // Reset 200 cycles into a scan aborts it
        @(negedge clk_in);
        horz_patterns = range_vec(5, 30);
        vert_patterns = range_vec(300, 350);
        start_bound   = 1'b1;
        @(posedge clk_in);
        #1;
        start_bound = 1'b0;
        repeat (199) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        check("abort bound_x", bound_x, 0);
        check("abort bound_y", bound_y, 0);
        check("abort valid", valid_bound, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        count_valids(600, cnt);
        check("abort no_valid", cnt, 0);

        run_scan("zeros", '0, '0);
        hv = '0;
        hv[0] = 1'b1;
        vv = '0;
        vv[N-1] = 1'b1;
        run_scan("single", hv, vv);

        // Inputs and start churn during the scan; the captured vectors rule
        hv = rand_vec();
        vv = rand_vec() | range_vec(200, 210);
        @(negedge clk_in);
        horz_patterns = hv;
        vert_patterns = vv;
        start_bound   = 1'b1;
        @(posedge clk_in);
        for (int c = 0; c < 100; c++) begin
            #1;
            horz_patterns = rand_vec();
            vert_patterns = rand_vec();
            start_bound   = ~start_bound;
            @(posedge clk_in);
        end
        #1;
        start_bound = 1'b0;
        wait_valid(cyc);
        check("churn latency", cyc, N + 1 - 100);
        check_bounds("churn", hv, vv);
        count_valids(600, cnt);
        check("churn single_valid", cnt, 0);

`ifdef QR_BOUNDS_RUN_FILTER_EN
        hv = range_vec(10, 11) | range_vec(100, 120);
        run_scan("short_run", hv, range_vec(476, 479));
        check("short_run x_lo const", bound_x[0], 100);
        check("short_run x_hi const", bound_x[1], 120);
`endif

        for (int t = 0; t < 10; t++) begin
            run_scan($sformatf("rand%0d", t), rand_vec(), rand_vec());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
